// File: rtl/instr_fetch_sequencer.sv
// Fetch/issue sequencer: owns the PC, fetches instructions into IR over a req/ready port,
// hands each one to the datapath controller via its s/w handshake and stops on HALT.
module instr_fetch_sequencer #(
  parameter int                ADDR_W      = 9,
  parameter int                INSTR_W     = 16,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter logic [2:0]        HALT_OPCODE = 3'b111,
  parameter int                CNT_W       = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               mem_rd,
  input  logic               mem_ready,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic [INSTR_W-1:0] ir,
  output logic               exec_s,
  input  logic               exec_w,
  output logic [ADDR_W-1:0]  pc,
  output logic               halted,
  output logic [CNT_W-1:0]   retired
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    START  = 3'd3,
    ACK    = 3'd4,
    BUSY   = 3'd5,
    HALT   = 3'd6
  } state_t;

  state_t state;
  state_t state_next;
  logic   capture;
  logic   retire;

  // State, PC, IR and retire counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      pc      <= RESET_PC;
      ir      <= '0;
      retired <= '0;
    end else begin
      state <= state_next;
      if (capture) begin
        ir <= mem_rdata;
      end
      if (retire) begin
        pc <= pc + {{(ADDR_W-1){1'b0}}, 1'b1};
        // Saturate rather than wrap so a long run never reports a small count
        if (retired != {CNT_W{1'b1}}) begin
          retired <= retired + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
    end
  end

  // Next-state logic with IR capture and retire strobes
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    retire     = 1'b0;
    case (state)
      IDLE: begin
        if (run) state_next = FETCH;
        else     state_next = IDLE;
      end
      FETCH: begin
        if (mem_ready) begin
          capture    = 1'b1;
          state_next = DECODE;
        end else begin
          state_next = FETCH;
        end
      end
      DECODE: begin
        if (ir[INSTR_W-1 -: 3] == HALT_OPCODE) state_next = HALT;
        else if (exec_w)                      state_next = START;
        else                                  state_next = DECODE;
      end
      START: state_next = ACK;
      ACK: begin
        if (!exec_w) state_next = BUSY;
        else         state_next = ACK;
      end
      BUSY: begin
        if (exec_w) begin
          retire     = 1'b1;
          state_next = run ? FETCH : IDLE;
        end else begin
          state_next = BUSY;
        end
      end
      HALT:    state_next = HALT;
      default: state_next = IDLE;
    endcase
  end

  assign mem_rd   = (state == FETCH);
  assign exec_s   = (state == START);
  assign halted   = (state == HALT);
  assign mem_addr = pc;

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// Directed self-checking bench for instr_fetch_sequencer: a default-width instance plus a
// 3-bit-address instance starting at PC 7 for the wrap case.
module tb_instr_fetch_sequencer;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, run, mem_ready, exec_w;
  logic [15:0] mem_rdata;
  logic [8:0]  mem_addr, pc;
  logic        mem_rd, exec_s, halted;
  logic [15:0] ir, retired;

  logic        w_reset, w_run, w_mem_ready, w_exec_w;
  logic [15:0] w_mem_rdata;
  logic [2:0]  w_mem_addr, w_pc;
  logic        w_mem_rd, w_exec_s, w_halted;
  logic [15:0] w_ir, w_retired;

  int tests_run = 0;
  int tests_failed = 0;

  instr_fetch_sequencer dut (
    .clk(clk), .reset(reset), .run(run), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .ir(ir), .exec_s(exec_s),
    .exec_w(exec_w), .pc(pc), .halted(halted), .retired(retired)
  );

  instr_fetch_sequencer #(.ADDR_W(3), .RESET_PC(3'd7)) dut_wrap (
    .clk(clk), .reset(w_reset), .run(w_run), .mem_addr(w_mem_addr), .mem_rd(w_mem_rd),
    .mem_ready(w_mem_ready), .mem_rdata(w_mem_rdata), .ir(w_ir), .exec_s(w_exec_s),
    .exec_w(w_exec_w), .pc(w_pc), .halted(w_halted), .retired(w_retired)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are checked there too
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; mem_ready = 1'b0; mem_rdata = 16'h0000; exec_w = 1'b1;
    w_reset = 1'b1; w_run = 1'b0; w_mem_ready = 1'b0; w_mem_rdata = 16'h0000; w_exec_w = 1'b1;
    @(negedge clk);
    tick();
    reset = 1'b0; w_reset = 1'b0;
    check("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
    check("rst_exec_s", {31'd0, exec_s}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_pc", {23'd0, pc}, 32'd0);
    check("rst_ir", {16'd0, ir}, 32'd0);
    check("rst_retired", {16'd0, retired}, 32'd0);

    // 1: fetch with mem_ready on the third FETCH cycle
    run = 1'b1;
    tick();
    check("t1_rd_c1", {31'd0, mem_rd}, 32'd1);
    check("t1_addr", {23'd0, mem_addr}, 32'd0);
    tick();
    check("t1_rd_c2", {31'd0, mem_rd}, 32'd1);
    tick();
    check("t1_rd_c3", {31'd0, mem_rd}, 32'd1);
    mem_ready = 1'b1; mem_rdata = 16'hA0E1;
    tick();
    mem_ready = 1'b0; mem_rdata = 16'h0000;
    check("t1_rd_off", {31'd0, mem_rd}, 32'd0);
    check("t1_ir", {16'd0, ir}, 32'h0000A0E1);
    check("t1_s_decode", {31'd0, exec_s}, 32'd0);
    tick();
    check("t1_s_pulse", {31'd0, exec_s}, 32'd1);
    tick();
    check("t1_s_drop", {31'd0, exec_s}, 32'd0);

    // 2: controller drops w for four cycles after taking s
    exec_w = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t2_pc_busy", {23'd0, pc}, 32'd0);
      check("t2_ret_busy", {16'd0, retired}, 32'd0);
      check("t2_s_busy", {31'd0, exec_s}, 32'd0);
    end
    exec_w = 1'b1;
    tick();
    check("t2_pc", {23'd0, pc}, 32'd1);
    check("t2_retired", {16'd0, retired}, 32'd1);
    check("t2_rd", {31'd0, mem_rd}, 32'd1);
    check("t2_addr", {23'd0, mem_addr}, 32'd1);
    check("t2_ir_hold", {16'd0, ir}, 32'h0000A0E1);
    mem_ready = 1'b1; mem_rdata = 16'h2345;
    tick();
    mem_ready = 1'b0;
    check("t2_ir2", {16'd0, ir}, 32'h00002345);
    tick();
    tick();
    exec_w = 1'b0;
    tick();
    exec_w = 1'b1;
    tick();
    check("t2_pc2", {23'd0, pc}, 32'd2);
    check("t2_addr2", {23'd0, mem_addr}, 32'd2);

    // 3: HALT opcode at address 2
    mem_ready = 1'b1; mem_rdata = 16'hE000;
    tick();
    mem_ready = 1'b0;
    check("t3_ir", {16'd0, ir}, 32'h0000E000);
    check("t3_not_yet", {31'd0, halted}, 32'd0);
    tick();
    check("t3_halted", {31'd0, halted}, 32'd1);
    check("t3_pc", {23'd0, pc}, 32'd2);
    check("t3_retired", {16'd0, retired}, 32'd2);
    for (int i = 0; i < 4; i++) begin
      run = i[0];
      tick();
      check("t3_stay", {31'd0, halted}, 32'd1);
      check("t3_no_s", {31'd0, exec_s}, 32'd0);
      check("t3_no_rd", {31'd0, mem_rd}, 32'd0);
    end
    run = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t3_rst_halted", {31'd0, halted}, 32'd0);
    check("t3_rst_pc", {23'd0, pc}, 32'd0);

    // 4: run dropped during BUSY; DECODE also waits while w is low
    run = 1'b1;
    tick();
    mem_ready = 1'b1; mem_rdata = 16'h1111;
    tick();
    mem_ready = 1'b0;
    exec_w = 1'b0;
    tick();
    check("t4_decode_wait", {31'd0, exec_s}, 32'd0);
    exec_w = 1'b1;
    tick();
    check("t4_s", {31'd0, exec_s}, 32'd1);
    tick();
    exec_w = 1'b0;
    tick();
    run = 1'b0; exec_w = 1'b1;
    tick();
    check("t4_pc", {23'd0, pc}, 32'd1);
    check("t4_retired", {16'd0, retired}, 32'd1);
    check("t4_idle_rd", {31'd0, mem_rd}, 32'd0);
    tick();
    check("t4_idle_rd2", {31'd0, mem_rd}, 32'd0);
    run = 1'b1;
    tick();
    check("t4_resume_rd", {31'd0, mem_rd}, 32'd1);
    check("t4_resume_addr", {23'd0, mem_addr}, 32'd1);

    // 6: reset mid-FETCH, then a late mem_ready while idle
    tick();
    reset = 1'b1; run = 1'b0;
    tick();
    reset = 1'b0;
    check("t6_rd_drop", {31'd0, mem_rd}, 32'd0);
    mem_ready = 1'b1; mem_rdata = 16'hBEEF;
    tick();
    tick();
    mem_ready = 1'b0;
    check("t6_ir", {16'd0, ir}, 32'd0);
    check("t6_pc", {23'd0, pc}, 32'd0);
    check("t6_retired", {16'd0, retired}, 32'd0);
    check("t6_rd", {31'd0, mem_rd}, 32'd0);

    // 5: 3-bit PC wraps from 7 to 0
    w_run = 1'b1;
    tick();
    check("t5_addr7", {29'd0, w_mem_addr}, 32'd7);
    w_mem_ready = 1'b1; w_mem_rdata = 16'h0001;
    tick();
    w_mem_ready = 1'b0;
    tick();
    tick();
    w_exec_w = 1'b0;
    tick();
    w_exec_w = 1'b1;
    tick();
    check("t5_pc_wrap", {29'd0, w_pc}, 32'd0);
    check("t5_addr_wrap", {29'd0, w_mem_addr}, 32'd0);
    check("t5_rd", {31'd0, w_mem_rd}, 32'd1);
    check("t5_retired", {16'd0, w_retired}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
